// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch display path: status codes, segment
// patterns, converter states and digit positions.
package stopwatch_pkg;

    // Status word driven by the stopwatch core
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RUN     = 2'b01;
    localparam logic [1:0] ST_PAUSE   = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    // Active-low segment patterns, bit6=g ... bit0=a
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Binary-to-BCD converter sequencing
    typedef enum logic [1:0] {
        CV_IDLE = 2'd0,
        CV_CONV = 2'd1,
        CV_LOAD = 2'd2
    } conv_state_t;

    // Digit positions, right to left on the board
    localparam logic [1:0] DIG_SEC_ONES = 2'd0;
    localparam logic [1:0] DIG_SEC_TENS = 2'd1;
    localparam logic [1:0] DIG_MIN_ONES = 2'd2;
    localparam logic [1:0] DIG_MIN_TENS = 2'd3;

    // Decimal nibble to segment pattern; non-decimal codes show a dash
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

    // Double-dabble correction: a nibble of 5 or more gets 3 added before the shift
    function automatic logic [3:0] dabble_adjust(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 8-bit binary to three BCD nibbles,
// one shift per clock, eight clocks after the start pulse.
module bin2bcd_seq
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] bin,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       done
);

    logic [7:0]  bin_sr;
    logic [11:0] bcd_sr;
    logic [2:0]  iter_cnt;
    logic        busy;
    logic [3:0]  adj_tens;
    logic [3:0]  adj_ones;

    // Correct tens/ones before each shift; hundreds never exceeds 2 for an 8-bit input
    always_comb begin
        adj_tens = dabble_adjust(bcd_sr[7:4]);
        adj_ones = dabble_adjust(bcd_sr[3:0]);
    end

    // Load on start, then shift the binary MSB into the BCD field once per clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr   <= '0;
            bcd_sr   <= '0;
            iter_cnt <= '0;
            busy     <= 1'b0;
        end else if (start) begin
            bin_sr   <= bin;
            bcd_sr   <= '0;
            iter_cnt <= '0;
            busy     <= 1'b1;
        end else if (busy) begin
            bcd_sr   <= {bcd_sr[10:8], adj_tens, adj_ones, bin_sr[7]};
            bin_sr   <= {bin_sr[6:0], 1'b0};
            iter_cnt <= iter_cnt + 3'd1;
            if (iter_cnt == 3'd7) begin
                busy <= 1'b0;
            end
        end
    end

    // done marks the cycle of the final shift, so results are stable right after it
    assign done     = busy && (iter_cnt == 3'd7);
    assign hundreds = bcd_sr[11:8];
    assign tens     = bcd_sr[7:4];
    assign ones     = bcd_sr[3:0];

endmodule

// File: rtl/stopwatch_display.sv
// MM.SS driver for a 4-digit common-anode multiplexed 7-segment display.
// Snapshots the stopwatch time, converts it to BCD, scans the digits and
// blinks the display while the stopwatch is paused.
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] minutes,
    input  logic [5:0] seconds,
    input  logic [1:0] status,
    output logic [6:0] seg_n,
    output logic [3:0] an_n,
    output logic       dp_n,
    output logic       min_ovf,
    output logic       bcd_valid
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    conv_state_t state, state_next;

    logic [7:0] snap_min;
    logic [5:0] snap_sec;
    logic       force_conv;
    logic       inputs_differ;
    logic       conv_start;
    logic       conv_done;
    logic       load_en;

    logic [3:0] min_h, min_t, min_o;
    logic [3:0] sec_h, sec_t, sec_o;
    logic       min_done, sec_done;

    logic [3:0] disp_min_h, disp_min_t, disp_min_o;
    logic [3:0] disp_sec_t, disp_sec_o;

    logic [SCAN_W-1:0]  scan_cnt;
    logic [1:0]         digit_idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;

    logic [6:0] digit_seg;
    logic [3:0] digit_an;
    logic       digit_dp;

    // force_conv guarantees a first conversion even if the inputs happen to equal the reset snapshot
    assign inputs_differ = force_conv || ({minutes, seconds} != {snap_min, snap_sec});
    assign conv_done     = min_done && sec_done;

    bin2bcd_seq u_min_bcd (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (conv_start),
        .bin      (minutes),
        .hundreds (min_h),
        .tens     (min_t),
        .ones     (min_o),
        .done     (min_done)
    );

    bin2bcd_seq u_sec_bcd (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (conv_start),
        .bin      ({2'b00, seconds}),
        .hundreds (sec_h),
        .tens     (sec_t),
        .ones     (sec_o),
        .done     (sec_done)
    );

    // Converter sequencing: start on any input change, wait for the shifts, then load once
    always_comb begin
        state_next = state;
        conv_start = 1'b0;
        load_en    = 1'b0;
        bcd_valid  = 1'b0;
        case (state)
            CV_IDLE: begin
                if (inputs_differ) begin
                    conv_start = 1'b1;
                    state_next = CV_CONV;
                end else begin
                    bcd_valid = 1'b1;
                end
            end
            CV_CONV: begin
                if (conv_done) begin
                    state_next = CV_LOAD;
                end
            end
            CV_LOAD: begin
                load_en    = 1'b1;
                state_next = CV_IDLE;
            end
            default: state_next = CV_IDLE;
        endcase
    end

    // Converter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Snapshot of the value being converted; all-ones after reset so the first compare misses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_min   <= '1;
            snap_sec   <= '1;
            force_conv <= 1'b1;
        end else if (conv_start) begin
            snap_min   <= minutes;
            snap_sec   <= seconds;
            force_conv <= 1'b0;
        end
    end

    // Display registers; an out-of-range seconds hundreds digit saturates seconds tens to a dash
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_min_h <= '0;
            disp_min_t <= '0;
            disp_min_o <= '0;
            disp_sec_t <= '0;
            disp_sec_o <= '0;
        end else if (load_en) begin
            disp_min_h <= min_h;
            disp_min_t <= min_t;
            disp_min_o <= min_o;
            disp_sec_t <= (sec_h == 4'd0) ? sec_t : 4'hF;
            disp_sec_o <= sec_o;
        end
    end

    // Minutes of 100 or more leave a non-zero hundreds digit, which cannot fit in MM
    assign min_ovf = (disp_min_h != 4'd0);

    // Digit scan: each digit stays enabled for SCAN_DIV clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            digit_idx <= DIG_SEC_ONES;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Blink timer only runs while paused; any other status restarts it in the ON phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (status != ST_PAUSE) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Pick the pattern for the current digit, then apply overflow, illegal-status and blink masking
    always_comb begin
        digit_seg = SEG_BLANK;
        digit_dp  = 1'b1;
        digit_an  = ~(4'b0001 << digit_idx);
        case (digit_idx)
            DIG_SEC_ONES: digit_seg = seg_encode(disp_sec_o);
            DIG_SEC_TENS: digit_seg = seg_encode(disp_sec_t);
            DIG_MIN_ONES: begin
                digit_seg = min_ovf ? SEG_DASH : seg_encode(disp_min_o);
                digit_dp  = 1'b0;
            end
            DIG_MIN_TENS: digit_seg = min_ovf ? SEG_DASH : seg_encode(disp_min_t);
            default:      digit_seg = SEG_BLANK;
        endcase
        if (status == ST_ILLEGAL) begin
            digit_seg = SEG_DASH;
            digit_dp  = 1'b1;
        end
        if ((status == ST_PAUSE) && !blink_on) begin
            digit_an = 4'b1111;
            digit_dp = 1'b1;
        end
    end

    // Register the pin drivers so the anodes and segments switch together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n  <= 4'b1111;
            seg_n <= SEG_BLANK;
            dp_n  <= 1'b1;
        end else begin
            an_n  <= digit_an;
            seg_n <= digit_seg;
            dp_n  <= digit_dp;
        end
    end

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench for stopwatch_display with a fast scan (2 clocks/digit)
// and a fast blink (4 clocks per half-period).
module tb_stopwatch_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] minutes = 8'd0;
    logic [5:0] seconds = 6'd0;
    logic [1:0] status = 2'b00;
    logic [6:0] seg_n;
    logic [3:0] an_n;
    logic       dp_n;
    logic       min_ovf;
    logic       bcd_valid;

    int checks = 0;
    int failures = 0;

    logic [6:0] cap_seg [4];
    logic       cap_dp  [4];

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P6 = 7'b0000010;
    localparam logic [6:0] P7 = 7'b1111000;
    localparam logic [6:0] P9 = 7'b0010000;
    localparam logic [6:0] PDASH  = 7'b0111111;
    localparam logic [6:0] PBLANK = 7'b1111111;

    stopwatch_display #(
        .SCAN_DIV  (2),
        .BLINK_DIV (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .minutes   (minutes),
        .seconds   (seconds),
        .status    (status),
        .seg_n     (seg_n),
        .an_n      (an_n),
        .dp_n      (dp_n),
        .min_ovf   (min_ovf),
        .bcd_valid (bcd_valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] m, input logic [5:0] s, input logic [1:0] st);
        minutes = m;
        seconds = s;
        status  = st;
    endtask

    task automatic waitValid(input int bound, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bcd_valid && cycles < bound);
        if (!bcd_valid) begin
            cycles = bound + 1;
        end
    endtask

    task automatic captureDigits();
        for (int d = 0; d < 4; d++) begin
            cap_seg[d] = 'x;
            cap_dp[d]  = 1'bx;
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            case (an_n)
                4'b1110: begin cap_seg[0] = seg_n; cap_dp[0] = dp_n; end
                4'b1101: begin cap_seg[1] = seg_n; cap_dp[1] = dp_n; end
                4'b1011: begin cap_seg[2] = seg_n; cap_dp[2] = dp_n; end
                4'b0111: begin cap_seg[3] = seg_n; cap_dp[3] = dp_n; end
                default: ;
            endcase
        end
    endtask

    initial begin
        int lat;
        int valid_at;
        logic [6:0] seen5;
        logic exp_blank;

        // Reset state
        applyStimulus(8'd0, 6'd0, 2'b00);
        rst_n = 1'b0;
        #12;
        checkOutput("rst_an", 32'(an_n), 32'(4'b1111));
        checkOutput("rst_seg", 32'(seg_n), 32'(PBLANK));
        checkOutput("rst_dp", 32'(dp_n), 32'd1);
        checkOutput("rst_ovf", 32'(min_ovf), 32'd0);
        checkOutput("rst_valid", 32'(bcd_valid), 32'd0);

        // First conversion after release and the anode scan order
        @(negedge clk);
        rst_n = 1'b1;
        valid_at = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checkOutput("p1_an_e1", 32'(an_n), 32'(4'b1110));
                checkOutput("p1_seg_d0", 32'(seg_n), 32'(P0));
            end
            if (k == 3) checkOutput("p1_an_e3", 32'(an_n), 32'(4'b1101));
            if (k == 5) checkOutput("p1_an_e5", 32'(an_n), 32'(4'b1011));
            if (k == 7) checkOutput("p1_an_e7", 32'(an_n), 32'(4'b0111));
            if (k == 9) checkOutput("p1_an_e9", 32'(an_n), 32'(4'b1110));
            if (bcd_valid && valid_at == 0) valid_at = k;
        end
        checkOutput("p1_valid_at", 32'(valid_at), 32'd10);

        // 12:34
        applyStimulus(8'd12, 6'd34, 2'b01);
        waitValid(30, lat);
        checkOutput("p2_latency", 32'(lat), 32'd10);
        captureDigits();
        checkOutput("p2_d0", 32'(cap_seg[0]), 32'(P4));
        checkOutput("p2_d1", 32'(cap_seg[1]), 32'(P3));
        checkOutput("p2_d2", 32'(cap_seg[2]), 32'(P2));
        checkOutput("p2_d3", 32'(cap_seg[3]), 32'(P1));
        checkOutput("p2_dp0", 32'(cap_dp[0]), 32'd1);
        checkOutput("p2_dp2", 32'(cap_dp[2]), 32'd0);
        checkOutput("p2_dp3", 32'(cap_dp[3]), 32'd1);
        checkOutput("p2_ovf", 32'(min_ovf), 32'd0);

        // 150:07 overflows the minutes field
        applyStimulus(8'd150, 6'd7, 2'b01);
        waitValid(30, lat);
        checkOutput("p3_latency", 32'(lat), 32'd10);
        checkOutput("p3_ovf", 32'(min_ovf), 32'd1);
        captureDigits();
        checkOutput("p3_d0", 32'(cap_seg[0]), 32'(P7));
        checkOutput("p3_d1", 32'(cap_seg[1]), 32'(P0));
        checkOutput("p3_d2", 32'(cap_seg[2]), 32'(PDASH));
        checkOutput("p3_d3", 32'(cap_seg[3]), 32'(PDASH));

        // Illegal status: dashes everywhere, no separator
        applyStimulus(8'd150, 6'd7, 2'b11);
        captureDigits();
        for (int d = 0; d < 4; d++) begin
            checkOutput("p3_ill_seg", 32'(cap_seg[d]), 32'(PDASH));
            checkOutput("p3_ill_dp", 32'(cap_dp[d]), 32'd1);
        end

        // Blink while paused: dark during clocks 5-8 and 13-16
        applyStimulus(8'd150, 6'd7, 2'b10);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_blank = ((k >= 5) && (k <= 8)) || ((k >= 13) && (k <= 16));
            checkOutput("p4_blank", 32'(an_n == 4'b1111), 32'(exp_blank));
            if (exp_blank) checkOutput("p4_blank_dp", 32'(dp_n), 32'd1);
        end
        applyStimulus(8'd150, 6'd7, 2'b01);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checkOutput("p4_resume", 32'(an_n == 4'b1111), 32'd0);
        end

        // Change during conversion: 5 lands first, then 6
        applyStimulus(8'd0, 6'd5, 2'b01);
        @(negedge clk);
        applyStimulus(8'd0, 6'd6, 2'b01);
        valid_at = 0;
        seen5 = 'x;
        for (int k = 2; k <= 30; k++) begin
            @(negedge clk);
            if ((k >= 11) && (k <= 19) && (an_n == 4'b1110)) seen5 = seg_n;
            if (bcd_valid && valid_at == 0) valid_at = k;
        end
        checkOutput("p5_first_val", 32'(seen5), 32'(P5));
        checkOutput("p5_valid_at", 32'(valid_at), 32'd20);
        captureDigits();
        checkOutput("p5_d0", 32'(cap_seg[0]), 32'(P6));
        checkOutput("p5_d1", 32'(cap_seg[1]), 32'(P0));
        checkOutput("p5_d3", 32'(cap_seg[3]), 32'(P0));
        checkOutput("p5_ovf", 32'(min_ovf), 32'd0);

        // Reset in the middle of a conversion
        applyStimulus(8'd45, 6'd59, 2'b01);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("p6_an", 32'(an_n), 32'(4'b1111));
        checkOutput("p6_seg", 32'(seg_n), 32'(PBLANK));
        checkOutput("p6_dp", 32'(dp_n), 32'd1);
        checkOutput("p6_valid", 32'(bcd_valid), 32'd0);
        checkOutput("p6_ovf", 32'(min_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        waitValid(30, lat);
        checkOutput("p6_latency", 32'(lat), 32'd10);
        captureDigits();
        checkOutput("p6_d0", 32'(cap_seg[0]), 32'(P9));
        checkOutput("p6_d1", 32'(cap_seg[1]), 32'(P5));
        checkOutput("p6_d2", 32'(cap_seg[2]), 32'(P5));
        checkOutput("p6_d3", 32'(cap_seg[3]), 32'(P4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
- Reads the stopwatch's minutes/seconds/status outputs and drives a 4-digit, common-anode, time-multiplexed 7-segment display as MM.SS.
- Converts binary to BCD with a sequential double-dabble converter.
- Scans digits at a programmable rate and blinks the display while paused.
- Sits between the stopwatch core and the board pins.

Parameters:
- SCAN_DIV, 50000, clocks each digit stays enabled (≥2).
- BLINK_DIV, 25000000, clocks per blink half-period in PAUSED (≥2).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- minutes  in  8  binary minutes 0..255.
- seconds  in  6  binary seconds 0..63; 60..63 displayed literally.
- status  in  2  00 IDLE, 01 RUNNING, 10 PAUSED, 11 illegal.
- seg_n  out  7  segments active-low, bit0=a … bit6=g.
- an_n  out  4  digit enables active-low; an_n[0] = seconds ones, an_n[3] = minutes tens.
- dp_n  out  1  decimal point active-low; lit on digit 2 as MM.SS separator.
- min_ovf  out  1  high while displayed minutes ≥ 100.
- bcd_valid  out  1  high when the display registers match the current inputs.

Behaviour:
- Reset values (asserted asynchronously, held while rst_n=0):
  - Outputs: an_n=1111, seg_n=1111111, dp_n=1, min_ovf=0, bcd_valid=0.
  - Display digit regs = 0; snapshot = all-ones (forces a conversion after release); converter IDLE; scan counter = 0; digit index = 0; blink phase = ON.
- Converter FSM, states IDLE → CONV → LOAD → IDLE:
  - IDLE: if {minutes,seconds} ≠ snapshot, capture inputs into snapshot, load shift regs, clear iteration count, go CONV, bcd_valid←0.
  - CONV: 8 iterations, one per clock. Add-3 to any BCD nibble ≥5, then shift left one bit. Seconds are zero-extended to 8 bits.
  - LOAD: write minutes hundreds/tens/ones and seconds tens/ones into display regs. Set min_ovf = (snapshot minutes ≥ 100). Go IDLE.
  - bcd_valid = 1 in IDLE when snapshot equals inputs.
- Conversion latency: input change sampled at edge 1, display regs updated at edge 10 (10 clocks).
- Inputs changing during CONV/LOAD are ignored. The IDLE compare picks them up on the next clock, so the latest value always lands.
- Scan counter:
  - Counts 0..SCAN_DIV-1. At wrap, digit index increments 0→1→2→3→0.
  - an_n, seg_n and dp_n are registered from the digit index: one-cycle lag, glitch-free.
  - After reset release, digit 0 is driven from the first edge.
- Digit content:
  - 0 = seconds ones, 1 = seconds tens, 2 = minutes ones, 3 = minutes tens.
  - Leading zeros are shown.
  - If min_ovf, digits 3 and 2 show dash (g only, 0111111).
  - Status 11: all digits show dash and dp_n=1.
- Blink:
  - status = 10: blink counter runs and toggles phase every BLINK_DIV clocks. During the OFF phase: an_n=1111, dp_n=1.
  - On any cycle status ≠ 10: counter cleared, phase = ON.
  - Entering PAUSED therefore always starts with a full ON half-period.
- Segment codes (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - dash=0111111, blank=1111111
- Reset mid-conversion or mid-scan: everything returns to reset values immediately; a fresh conversion starts after release.

Decomposition:
- Package stopwatch_pkg:
  - Status encodings ST_IDLE, ST_RUN, ST_PAUSE.
  - Segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK.
  - Converter state encodings.
  - Digit-index constants.
- Sub-module bin2bcd_seq:
  - 8-bit binary in, start pulse, 3 BCD nibbles out, done pulse.
  - Instantiated twice, for minutes and seconds. Both run in lockstep.
- Top holds the snapshot, display regs, scan and blink logic.

Test Plan:
1. Release reset with minutes=0, seconds=0 → bcd_valid rises by cycle 11; digit 0 shows seg_n=1000000; an_n cycles 1110,1101,1011,0111 every SCAN_DIV clocks.
2. SCAN_DIV=2; minutes=12, seconds=34 → 10 clocks later digits 0..3 show 4,3,2,1 (0011001, 0110000, 0100100, 1111001); dp_n=0 only while an_n=1011.
3. minutes=150, seconds=7 → min_ovf=1; digits 3,2 seg_n=0111111; digit 0 = 1111000; digit 1 = 1000000.
4. BLINK_DIV=4, status=10 for 20 clocks → an_n=1111 during clocks 5–8 and 13–16. Set status=01 → next edge display is steady and phase is ON.
5. seconds 5→6 on the cycle after a conversion starts → 5 is displayed first; bcd_valid stays 0; 6 is displayed ≤10 clocks later, then bcd_valid=1.
6. Assert rst_n=0 mid-CONV with SCAN_DIV=2 → same cycle: an_n=1111, seg_n=1111111, bcd_valid=0. After release, the display equals the current inputs within 11 clocks.
